// File: rtl/dram_burst_pkg.sv
// Shared constants, state encoding and word/address types for the DRAM burst master.
package dram_burst_pkg;

    localparam int COL_NUM      = 128;
    localparam int DDR_ADDR_LEN = 25;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DRAIN,
        DONE
    } burst_state_t;

    typedef logic [COL_NUM-1:0]      dram_word_t;
    typedef logic [DDR_ADDR_LEN-1:0] dram_addr_t;

endpackage

// File: rtl/dram_burst_master_if.sv
// DRAM beat bus: at most one request per cycle; read data is returned combinationally in the same cycle.
interface dram_burst_master_if;
    import dram_burst_pkg::*;

    logic       DRAM_valid;
    logic       DRAM_wr_en;
    dram_addr_t DRAM_addr;
    dram_word_t DRAM_rd_data;
    dram_word_t DRAM_wr_data;

    modport master (
        output DRAM_valid,
        output DRAM_wr_en,
        output DRAM_addr,
        output DRAM_wr_data,
        input  DRAM_rd_data
    );

    modport slave (
        input  DRAM_valid,
        input  DRAM_wr_en,
        input  DRAM_addr,
        input  DRAM_wr_data,
        output DRAM_rd_data
    );

endinterface

// File: rtl/dram_burst_fifo.sv
// First-word-fall-through FIFO: a pushed word is visible at head the cycle after the push.
// No internal backpressure; push while full and pop while empty are ignored.
module dram_burst_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dram_burst_master.sv
// Burst initiator: one DRAM beat per cycle; reads reach rd_valid one cycle later, issue stalls on a full FIFO or missing write data.
// Optional beat counters stat_rd_beats/stat_wr_beats exist only when DRAM_BURST_STATS_EN is defined.
module dram_burst_master
    import dram_burst_pkg::*;
#(
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  dram_addr_t         cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  dram_word_t         wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output dram_word_t         rd_data,
    output logic               busy,
    output logic               done,
`ifdef DRAM_BURST_STATS_EN
    output logic [31:0]        stat_rd_beats,
    output logic [31:0]        stat_wr_beats,
`endif
    dram_burst_master_if.master dram
);

    burst_state_t     state;
    dram_addr_t       base;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             beat;
    logic             last_beat;

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign beat      = dram.DRAM_valid;
    assign last_beat = (cnt == len - LEN_W'(1));
    assign fifo_push = (state == RD) && !fifo_full;
    assign rd_valid  = !fifo_empty;

    always_comb begin
        dram.DRAM_valid   = 1'b0;
        dram.DRAM_wr_en   = 1'b0;
        dram.DRAM_addr    = '0;
        dram.DRAM_wr_data = '0;
        wr_ready          = 1'b0;
        case (state)
            RD: begin
                dram.DRAM_valid = !fifo_full;
                dram.DRAM_addr  = base + dram_addr_t'(cnt);
            end
            WR: begin
                dram.DRAM_valid   = wr_valid;
                dram.DRAM_wr_en   = 1'b1;
                dram.DRAM_addr    = base + dram_addr_t'(cnt);
                dram.DRAM_wr_data = wr_data;
                wr_ready          = wr_valid;
            end
            default: ;
        endcase
    end

    // Status outputs are registered alongside the state so they never glitch on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            cnt         <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base        <= cmd_addr;
                        len         <= cmd_len;
                        cnt         <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (cmd_wr) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD, WR: begin
                    if (beat) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            if (state == RD) begin
                                state <= DRAIN;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dram_burst_fifo #(
        .WIDTH (COL_NUM),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (dram.DRAM_rd_data),
        .pop       (rd_valid && rd_ready),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef DRAM_BURST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_beats <= '0;
            stat_wr_beats <= '0;
        end else begin
            if (beat && !dram.DRAM_wr_en && (stat_rd_beats != 32'hFFFF_FFFF))
                stat_rd_beats <= stat_rd_beats + 32'd1;
            if (beat && dram.DRAM_wr_en && (stat_wr_beats != 32'hFFFF_FFFF))
                stat_wr_beats <= stat_wr_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_burst_master.sv
// Bench for dram_burst_master: directed command table, reset-abort sequence and random bursts
// against a queue-based model of the expected DRAM beats, read returns and done timing.
module tb_dram_burst_master;
    import dram_burst_pkg::*;

    localparam int LEN_W = 12;

    typedef struct {
        logic       wr;
        dram_addr_t addr;
        int         len;
        int         rd_hold;        // cycles after acceptance with rd_ready held low
        bit         rd_rand;
        int         wr_mode;        // 0 always valid, 1 random, 2 pattern 1,0,1,1
        int         exp_lat;        // acceptance-to-done cycles, -1 = unchecked
        int         exp_hold_beats; // beats issued during rd_hold window, -1 = unchecked
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_wr;
    dram_addr_t       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid, wr_ready;
    dram_word_t       wr_data;
    logic             rd_valid, rd_ready;
    dram_word_t       rd_data;
    logic             busy, done;
`ifdef DRAM_BURST_STATS_EN
    logic [31:0]      stat_rd_beats, stat_wr_beats;
`endif

    always #5 clk = ~clk;

    dram_burst_master_if dram ();

    dram_burst_master #(.LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
`ifdef DRAM_BURST_STATS_EN
        .stat_rd_beats (stat_rd_beats),
        .stat_wr_beats (stat_wr_beats),
`endif
        .dram          (dram)
    );

    // DRAM: unwritten locations read back their own address; storage aliases on the low 10 bits.
    dram_word_t mem   [0:1023];
    bit         wrote [0:1023];
    assign dram.DRAM_rd_data = wrote[dram.DRAM_addr[9:0]] ? mem[dram.DRAM_addr[9:0]]
                                                          : dram_word_t'(dram.DRAM_addr);
    always @(posedge clk) begin
        if (!rst && dram.DRAM_valid && dram.DRAM_wr_en) begin
            mem[dram.DRAM_addr[9:0]]   <= dram.DRAM_wr_data;
            wrote[dram.DRAM_addr[9:0]] <= 1'b1;
        end
    end

    // Reference image of DRAM contents, updated from the commands the bench issues.
    dram_word_t ref_mem   [0:1023];
    bit         ref_wrote [0:1023];

    function automatic dram_word_t ref_read(input dram_addr_t a);
        return ref_wrote[a[9:0]] ? ref_mem[a[9:0]] : dram_word_t'(a);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_n   = 0;
    int done_cyc = 0;
    int last_pop = 0;
    int st_rd    = 0;
    int st_wr    = 0;

    dram_addr_t lg_addr[$];
    logic       lg_wr[$];
    dram_word_t lg_data[$];
    int         lg_cyc[$];
    dram_word_t out_q[$];

    logic       s_cmd_ready, s_busy, s_done, s_rd_valid, s_dvalid, s_wr_en, s_wr_ready;
    dram_addr_t s_addr;
    dram_word_t s_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; samples, logs, advances one cycle.
    task automatic step();
        #1;
        s_cmd_ready = cmd_ready;
        s_busy      = busy;
        s_done      = done;
        s_rd_valid  = rd_valid;
        s_dvalid    = dram.DRAM_valid;
        s_wr_en     = dram.DRAM_wr_en;
        s_wr_ready  = wr_ready;
        s_addr      = dram.DRAM_addr;
        s_wdata     = dram.DRAM_wr_data;
        if (s_dvalid) begin
            lg_addr.push_back(s_addr);
            lg_wr.push_back(s_wr_en);
            lg_data.push_back(s_wr_en ? s_wdata : dram.DRAM_rd_data);
            lg_cyc.push_back(cyc);
        end
        if (rd_valid && rd_ready) begin
            out_q.push_back(rd_data);
            last_pop = cyc;
        end
        if (s_done) begin
            done_n++;
            done_cyc = cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        lg_addr.delete(); lg_wr.delete(); lg_data.delete(); lg_cyc.delete(); out_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        step();
        rst = 1'b0;
        st_rd = 0;
        st_wr = 0;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        dram_addr_t ea[$];
        dram_word_t ed[$];
        bit         pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int         acc_cyc, k, widx, d0, nb;
        bit         accepted, fin;
        clear_logs();
        d0 = done_n;
        for (int i = 0; i < v.len; i++) begin
            dram_addr_t a = v.addr + dram_addr_t'(i);
            dram_word_t w;
            ea.push_back(a);
            if (v.wr) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                ref_mem[a[9:0]]   = w;
                ref_wrote[a[9:0]] = 1'b1;
            end else begin
                w = ref_read(a);
            end
            ed.push_back(w);
        end
        if (v.wr) st_wr += v.len; else st_rd += v.len;

        accepted = 0; fin = 0; k = 0; widx = 0; acc_cyc = 0;
        for (int t = 0; t < 1000 && !fin; t++) begin
            cmd_valid = !accepted;
            cmd_wr    = v.wr;
            cmd_addr  = v.addr;
            cmd_len   = LEN_W'(v.len);
            case (v.wr_mode)
                1:       wr_valid = accepted && ($urandom_range(0, 1) == 1);
                2:       wr_valid = accepted && pat[k % 4];
                default: wr_valid = accepted;
            endcase
            if (!v.wr || widx >= ed.size()) wr_valid = 1'b0;
            wr_data  = wr_valid ? ed[widx] : {4{$urandom}};
            rd_ready = accepted && (k >= v.rd_hold) && (!v.rd_rand || $urandom_range(0, 1) == 1);
            step();
            if (cmd_valid && s_cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc - 1;
            end else if (accepted) begin
                k++;
            end
            if (wr_valid && s_wr_ready) widx++;
            if (done_n != d0) fin = 1;
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done never seen, got %0d beats of %0d", tag, lg_addr.size(), v.len);
            do_reset();
            return;
        end

        cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
        step();
        chk({tag, " done_one_cycle"}, s_done, 1'b0);
        chk({tag, " ready_after_done"}, s_cmd_ready, 1'b1);
        chk({tag, " beat_count"}, lg_addr.size(), v.len);
        for (int i = 0; i < v.len && i < lg_addr.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), lg_addr[i], ea[i]);
            chk($sformatf("%s wr_en[%0d]", tag, i), lg_wr[i], v.wr);
            if (v.wr) chk($sformatf("%s wdata[%0d]", tag, i), lg_data[i], ed[i]);
        end
        chk({tag, " rd_count"}, out_q.size(), v.wr ? 0 : v.len);
        if (!v.wr)
            for (int i = 0; i < v.len && i < out_q.size(); i++)
                chk($sformatf("%s rd_data[%0d]", tag, i), out_q[i], ed[i]);
        chk({tag, " wr_consumed"}, widx, v.wr ? v.len : 0);
        if (v.exp_lat >= 0) chk({tag, " done_latency"}, done_cyc - acc_cyc, v.exp_lat);
        if (v.exp_hold_beats >= 0) begin
            nb = 0;
            foreach (lg_cyc[i]) if (lg_cyc[i] <= acc_cyc + v.rd_hold) nb++;
            chk({tag, " beats_while_held"}, nb, v.exp_hold_beats);
        end
        if (!v.wr && v.len > 0 && v.rd_hold == 0 && !v.rd_rand && lg_cyc.size() == v.len) begin
            chk({tag, " back_to_back"}, lg_cyc[v.len-1] - lg_cyc[0], v.len - 1);
            chk({tag, " done_after_empty"}, done_cyc - last_pop, 2);
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   d0;
        tbl[0] = '{wr:1'b0, addr:25'h10,      len:4, rd_hold:0,  rd_rand:0, wr_mode:0, exp_lat:7,  exp_hold_beats:-1};
        tbl[1] = '{wr:1'b0, addr:25'h20,      len:8, rd_hold:10, rd_rand:0, wr_mode:0, exp_lat:-1, exp_hold_beats:4};
        tbl[2] = '{wr:1'b1, addr:25'h100,     len:3, rd_hold:0,  rd_rand:0, wr_mode:2, exp_lat:5,  exp_hold_beats:-1};
        tbl[3] = '{wr:1'b0, addr:25'h100,     len:3, rd_hold:0,  rd_rand:0, wr_mode:0, exp_lat:6,  exp_hold_beats:-1};
        tbl[4] = '{wr:1'b0, addr:25'h55,      len:0, rd_hold:0,  rd_rand:0, wr_mode:0, exp_lat:1,  exp_hold_beats:-1};
        tbl[5] = '{wr:1'b0, addr:25'h1FFFFFF, len:2, rd_hold:0,  rd_rand:0, wr_mode:0, exp_lat:5,  exp_hold_beats:-1};
        tbl[6] = '{wr:1'b1, addr:25'h1FFFFFE, len:3, rd_hold:0,  rd_rand:0, wr_mode:0, exp_lat:4,  exp_hold_beats:-1};
        tbl[7] = '{wr:1'b0, addr:25'h1FFFFFE, len:3, rd_hold:1,  rd_rand:1, wr_mode:0, exp_lat:-1, exp_hold_beats:-1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(negedge clk);

        // Idle outputs right after reset, with stray write data and rd_ready present.
        rst = 1'b0; wr_valid = 1'b1; wr_data = {4{$urandom}}; rd_ready = 1'b1;
        step();
        chk("reset cmd_ready", s_cmd_ready, 1'b1);
        chk("reset busy", s_busy, 1'b0);
        chk("reset done", s_done, 1'b0);
        chk("reset rd_valid", s_rd_valid, 1'b0);
        chk("reset wr_ready", s_wr_ready, 1'b0);
        chk("reset DRAM_valid", s_dvalid, 1'b0);
        chk("reset DRAM_wr_en", s_wr_en, 1'b0);
        chk("reset DRAM_addr", s_addr, 25'h0);
        chk("reset DRAM_wr_data", s_wdata, 128'h0);
        wr_valid = 1'b0;

        foreach (tbl[i]) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset during the third beat of a 10-beat read.
        clear_logs();
        d0 = done_n;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 25'h40; cmd_len = 12'd10; rd_ready = 1'b0;
        step();
        chk("rst_mid accepted", s_cmd_ready, 1'b1);
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_mid beats_before_reset", lg_addr.size(), 3);
        chk("rst_mid beat3_addr", s_addr, 25'h42);
        rst = 1'b0; st_rd = 0; st_wr = 0;
        step();
        chk("rst_mid DRAM_valid", s_dvalid, 1'b0);
        chk("rst_mid rd_valid", s_rd_valid, 1'b0);
        chk("rst_mid cmd_ready", s_cmd_ready, 1'b1);
        chk("rst_mid busy", s_busy, 1'b0);
        repeat (3) step();
        chk("rst_mid no_done", done_n - d0, 0);
        run_cmd('{wr:1'b0, addr:25'h7, len:1, rd_hold:0, rd_rand:0, wr_mode:0, exp_lat:4, exp_hold_beats:-1},
                "after_rst");

`ifdef DRAM_BURST_STATS_EN
        do_reset();
        chk("stats rd_after_rst", stat_rd_beats, 32'd0);
        chk("stats wr_after_rst", stat_wr_beats, 32'd0);
        run_cmd('{wr:1'b0, addr:25'h200, len:5, rd_hold:0, rd_rand:0, wr_mode:0, exp_lat:-1, exp_hold_beats:-1}, "stat_rd");
        run_cmd('{wr:1'b1, addr:25'h300, len:3, rd_hold:0, rd_rand:0, wr_mode:1, exp_lat:-1, exp_hold_beats:-1}, "stat_wr");
        chk("stats rd_5", stat_rd_beats, 32'd5);
        chk("stats wr_3", stat_wr_beats, 32'd3);
`endif

        for (int n = 0; n < 40; n++) begin
            vec_t r;
            r.wr             = 1'($urandom_range(0, 1));
            r.addr           = ($urandom_range(0, 3) == 0) ? 25'h1FFFFFF - dram_addr_t'($urandom_range(0, 8))
                                                           : dram_addr_t'($urandom_range(0, 63));
            r.len            = $urandom_range(0, 20);
            r.rd_hold        = $urandom_range(0, 6);
            r.rd_rand        = 1'($urandom_range(0, 1));
            r.wr_mode        = $urandom_range(0, 2);
            r.exp_lat        = -1;
            r.exp_hold_beats = -1;
            run_cmd(r, $sformatf("rnd%0d", n));
        end

`ifdef DRAM_BURST_STATS_EN
        chk("stats rd_total", stat_rd_beats, st_rd);
        chk("stats wr_total", stat_wr_beats, st_wr);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_burst_master.md
Name: dram_burst_master

Overview:
- Initiator side of the DDR3-DRAM interface (DRAM_valid/DRAM_wr_en/DRAM_addr/DRAM_rd_data/DRAM_wr_data).
- Accepts one burst command at a time (read or write, base address, beat count) from the compute side.
- Issues one DRAM beat per cycle at consecutive addresses.
- Read beats go out on a valid/ready stream through a small FIFO; write beats are pulled from a valid/ready input stream.

Parameters:
- COL_NUM, 128, DRAM data width in bits.
- DDR_ADDR_LEN, 25, DRAM address width.
- LEN_W, 12, width of cmd_len; maximum burst 2^LEN_W-1 beats.
- FIFO_DEPTH, 4, read-return FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  DDR_ADDR_LEN  base beat address
- cmd_len  in  LEN_W  beat count; 0 is legal
- wr_valid  in  1  write-data beat available
- wr_ready  out  1  write beat consumed this cycle
- wr_data  in  COL_NUM  write-data beat
- rd_valid  out  1  read beat available (FIFO head)
- rd_ready  in  1  consumer accepts the read beat
- rd_data  out  COL_NUM  read beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- DRAM_valid  out  1  beat request to DRAM
- DRAM_wr_en  out  1  1=write beat
- DRAM_addr  out  DDR_ADDR_LEN  beat address
- DRAM_rd_data  in  COL_NUM  read data, combinationally valid in the same cycle as a read request
- DRAM_wr_data  out  COL_NUM  write data

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State returns to IDLE; FIFO and all counters are cleared.
  - After the edge: cmd_ready=1, busy=0, done=0, rd_valid=0, wr_ready=0, DRAM_valid=0, DRAM_wr_en=0, DRAM_addr=0, DRAM_wr_data=0.
  - rst mid-burst aborts immediately. Remaining beats are dropped; queued read beats are discarded; no done pulse.
- States: IDLE, RD, WR, DRAIN, DONE.
- IDLE:
  - On cmd_valid, latch base=cmd_addr, len=cmd_len, beat counter cnt=0.
  - len==0 goes to DONE; cmd_wr=1 goes to WR; otherwise RD.
- RD:
  - DRAM_valid = !fifo_full; DRAM_wr_en=0; DRAM_addr = base+cnt, modulo 2^DDR_ADDR_LEN (wraps, no error).
  - On each posedge with DRAM_valid, DRAM_rd_data is pushed into the FIFO and cnt increments.
  - After the beat with cnt==len-1 is issued, go to DRAIN.
- WR:
  - DRAM_valid = wr_valid; wr_ready = wr_valid; DRAM_wr_en=1; DRAM_wr_data = wr_data (combinational pass-through); DRAM_addr = base+cnt.
  - A beat is consumed when wr_valid=1. After the beat with cnt==len-1, go to DONE.
  - Stalls are indefinite while wr_valid=0.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The next command is accepted no earlier than the following cycle.
- Outside RD/WR: DRAM_valid=0, DRAM_wr_en=0, wr_ready=0. DRAM_addr and DRAM_wr_data hold 0 while idle.
- Read FIFO:
  - First-word-fall-through: rd_valid = !empty, rd_data = head entry.
  - A pop happens on rd_valid&rd_ready.
  - Push and pop in the same cycle are allowed; occupancy stays unchanged.
  - Push is never attempted when full, because it is gated by DRAM_valid.
- Throughput: with rd_ready held at 1, reads run at 1 beat/cycle. First rd_valid appears the cycle after the first DRAM read.
- Beat ordering is preserved.
- cmd_valid while busy is ignored; the command is neither latched nor dropped silently. The issuer must hold it until cmd_ready.

Optional Feature:
- Macro: DRAM_BURST_STATS_EN.
- Defined: adds outputs stat_rd_beats[31:0] and stat_wr_beats[31:0].
  - Each counts DRAM read or write beats issued, saturating at 0xFFFFFFFF.
  - Both cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dram_burst_pkg:
  - Constants COL_NUM=128 and DDR_ADDR_LEN=25.
  - State enum burst_state_t {IDLE, RD, WR, DRAIN, DONE}.
  - Typedefs dram_word_t [COL_NUM-1:0] and dram_addr_t [DDR_ADDR_LEN-1:0].
- Sub-module dram_burst_fifo: synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst, push, push_data, pop, head, empty, full.

Test Plan:
- Read, rd_ready=1: cmd_addr=0x10, len=4, DRAM preloaded with mem[i]=i → 4 DRAM reads in 4 consecutive cycles at 0x10..0x13; rd_data sequence 0x10..0x13; done one cycle after the FIFO empties.
- Backpressure: read len=8 with rd_ready=0 → DRAM_valid drops after 4 beats (FIFO full); releasing rd_ready delivers all 8 in order with no loss or duplicates.
- Write with gaps: addr=0x100, len=3, wr_valid toggling 1,0,1,1 → writes at 0x100..0x102 with matching data; subsequent read-back returns identical words.
- len=0 and address wrap: cmd_len=0 → no DRAM_valid, done the cycle after acceptance. Read at addr=0x1FFFFFF, len=2 → addresses 0x1FFFFFF then 0x0000000.
- Reset mid-burst: rst asserted during beat 3 of a len=10 read → next cycle DRAM_valid=0, rd_valid=0, cmd_ready=1, no done; a new len=1 command completes normally.
- With DRAM_BURST_STATS_EN: read len=5 plus write len=3 → stat_rd_beats=5, stat_wr_beats=3; both 0 after rst.
